// File: rtl/page_table_walker.sv
// page_table_walker: two-port page-table walk backend with fixed latency, round-robin arbitration and valid-bit faults
module page_table_walker #(
  parameter int WALK_LATENCY = 4,
  parameter int LAT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PAGE_8B_RQST,
  input  logic [5:0]  PAGE_8B_LOOKUP,
  output logic [11:0] PAGE_8B_RECV,
  output logic        PAGE_8B_COMPLETE,
  input  logic        PAGE_32B_RQST,
  input  logic [3:0]  PAGE_32B_LOOKUP,
  output logic [7:0]  PAGE_32B_RECV,
  output logic        PAGE_32B_COMPLETE,
  input  logic        PT_WR_EN,
  input  logic        PT_WR_SEL,
  input  logic [5:0]  PT_WR_INDX,
  input  logic [5:0]  PT_WR_PPN,
  input  logic        PT_WR_VALID,
  output logic        PAGE_FAULT,
  output logic        WALK_BUSY
);
  typedef enum logic [1:0] {IDLE, WALK, RESP, WAIT_DROP} state_t;
  state_t state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic port_q, port_d, prio_q, prio_d;
  logic [5:0] vpn_q, vpn_d;
  logic [11:0] recv8_q, recv8_d;
  logic [7:0] recv32_q, recv32_d;
  logic cmp8_q, cmp8_d, cmp32_q, cmp32_d, fault_q, fault_d;
  logic [5:0] ppn8_mem [64];
  logic [3:0] ppn32_mem [16];
  logic [63:0] v8_q;
  logic [15:0] v32_q;
  logic [5:0] rd8;
  logic [3:0] rd32;
  logic rd_v, served, win;
  assign rd8 = ppn8_mem[vpn_q];
  assign rd32 = ppn32_mem[vpn_q[3:0]];
  assign rd_v = port_q ? v32_q[vpn_q[3:0]] : v8_q[vpn_q];
  assign served = port_q ? PAGE_32B_RQST : PAGE_8B_RQST;
  assign win = (PAGE_8B_RQST && PAGE_32B_RQST) ? prio_q : PAGE_32B_RQST;
  assign PAGE_8B_RECV = recv8_q;
  assign PAGE_32B_RECV = recv32_q;
  assign PAGE_8B_COMPLETE = cmp8_q;
  assign PAGE_32B_COMPLETE = cmp32_q;
  assign PAGE_FAULT = fault_q;
  assign WALK_BUSY = (state_q == WALK) || (state_q == RESP);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    port_d = port_q;
    prio_d = prio_q;
    vpn_d = vpn_q;
    recv8_d = recv8_q;
    recv32_d = recv32_q;
    cmp8_d = 1'b0;
    cmp32_d = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      IDLE: if (PAGE_8B_RQST || PAGE_32B_RQST) begin
        state_d = WALK;
        port_d = win;
        vpn_d = win ? {2'b00, PAGE_32B_LOOKUP} : PAGE_8B_LOOKUP;
        cnt_d = LAT_W'(WALK_LATENCY - 1);
        prio_d = (PAGE_8B_RQST && PAGE_32B_RQST) ? ~win : prio_q;
      end
      WALK: if (cnt_q == '0) begin
        state_d = RESP;
        cmp8_d = ~port_q;
        cmp32_d = port_q;
        fault_d = ~rd_v;
        recv8_d = port_q ? recv8_q : {vpn_q, rd_v ? rd8 : 6'h00};
        recv32_d = port_q ? {vpn_q[3:0], rd_v ? rd32 : 4'h0} : recv32_q;
      end else begin
        cnt_d = cnt_q - LAT_W'(1);
      end
      RESP: state_d = served ? WAIT_DROP : IDLE;
      WAIT_DROP: state_d = served ? WAIT_DROP : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      port_q <= 1'b0;
      prio_q <= 1'b0;
      vpn_q <= '0;
      recv8_q <= '0;
      recv32_q <= '0;
      cmp8_q <= 1'b0;
      cmp32_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      port_q <= port_d;
      prio_q <= prio_d;
      vpn_q <= vpn_d;
      recv8_q <= recv8_d;
      recv32_q <= recv32_d;
      cmp8_q <= cmp8_d;
      cmp32_q <= cmp32_d;
      fault_q <= fault_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v8_q <= '0;
      v32_q <= '0;
    end else if (PT_WR_EN) begin
      if (PT_WR_SEL) v32_q[PT_WR_INDX[3:0]] <= PT_WR_VALID;
      else v8_q[PT_WR_INDX] <= PT_WR_VALID;
    end
  end
  always_ff @(posedge clk) begin
    if (PT_WR_EN) begin
      if (PT_WR_SEL) ppn32_mem[PT_WR_INDX[3:0]] <= PT_WR_PPN[3:0];
      else ppn8_mem[PT_WR_INDX] <= PT_WR_PPN;
    end
  end
endmodule
